// File: rtl/dualcore_pkg.sv
// dualcore_pkg
// Shared types and constants for the dual-core fetch/store path.
//   core_id_t       : identifies a requesting core (0 or 1)
//   rsp_t           : in-flight read response record {valid, core_id}
//   RESET_PC        : PC value loaded by the PC counters on reset
//   BYTE_READY_VEC  : byte-ready vector address, shared with the PC counter
package dualcore_pkg;

  typedef logic core_id_t;

  localparam core_id_t CORE0 = 1'b0;
  localparam core_id_t CORE1 = 1'b1;

  typedef struct packed {
    logic     valid;
    core_id_t core_id;
  } rsp_t;

  localparam logic [11:0] RESET_PC       = 12'h000;
  localparam logic [11:0] BYTE_READY_VEC = 12'h7F4;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-requester round-robin arbiter with its priority pointer.
//   clk, rst     : clock, synchronous active-high reset
//   req0/req1    : request from core 0 / core 1
//   wen0/wen1    : request is a store
//   gnt0/gnt1    : one-hot grant (both 0 when idle or in reset)
// Build option: ARB_STORE_PRIORITY_EN -- on a read/store collision the store
// wins regardless of the pointer and the pointer is left alone.
module rr_arbiter2
  import dualcore_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic wen0,
  input  logic wen1,
  output logic gnt0,
  output logic gnt1
);

  core_id_t prio_q, prio_d;

`ifndef ARB_STORE_PRIORITY_EN
  // Request types do not affect arbitration in this build.
  logic unused_wen;
  assign unused_wen = wen0 ^ wen1;
`endif

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    prio_d = prio_q;
    if (!rst) begin
      if (req0 && req1) begin
`ifdef ARB_STORE_PRIORITY_EN
        if (wen0 != wen1) begin
          gnt0 = wen0;
          gnt1 = wen1;
        end else begin
          gnt0   = (prio_q == CORE0);
          gnt1   = (prio_q == CORE1);
          prio_d = gnt0 ? CORE1 : CORE0;
        end
`else
        gnt0   = (prio_q == CORE0);
        gnt1   = (prio_q == CORE1);
        // Loser of a contended cycle gets priority next time.
        prio_d = gnt0 ? CORE1 : CORE0;
`endif
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= CORE0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/dualcore_mem_arbiter.sv
// dualcore_mem_arbiter
// Serialises fetch/store requests from two cores onto one single-port
// synchronous (write-first) RAM and generates each core's stall.
//   clk, rst               : clock, synchronous active-high reset
//   cN_req/addr/wen/wdata  : core N request
//   cN_stall               : request present but not granted (combinational)
//   cN_rvalid/cN_rdata     : read response, one cycle after grant
//   cN_stall_cnt           : saturating count of stalled cycles
//   mem_addr/wen/wdata     : RAM port, from the current grant
//   mem_rdata              : RAM read data, one cycle after the address
// Build option: ARB_STORE_PRIORITY_EN (see rr_arbiter2).
module dualcore_mem_arbiter
  import dualcore_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_wen,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic              c1_req,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_wen,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c0_stall,
  output logic              c1_stall,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [CNT_W-1:0]  c0_stall_cnt,
  output logic [CNT_W-1:0]  c1_stall_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              gnt0, gnt1, gnt_valid, gnt_wen;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  rsp_t              rsp_q, rsp_d;
  logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d, c1_rdata_q, c1_rdata_d;
  logic [CNT_W-1:0]  c0_cnt_q, c0_cnt_d, c1_cnt_q, c1_cnt_d;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (c0_req),
    .req1 (c1_req),
    .wen0 (c0_wen),
    .wen1 (c1_wen),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_comb begin
    gnt_valid = gnt0 | gnt1;
    gnt_wen   = gnt1 ? c1_wen : c0_wen;

    // Idle cycles keep the last address so the RAM input is quiet.
    mem_addr    = gnt_valid ? (gnt1 ? c1_addr : c0_addr) : addr_hold_q;
    mem_wdata   = gnt1 ? c1_wdata : c0_wdata;
    mem_wen     = gnt_valid && gnt_wen;
    addr_hold_d = mem_addr;

    rsp_d.valid   = gnt_valid && !gnt_wen;
    rsp_d.core_id = gnt1 ? CORE1 : CORE0;

    c0_stall = c0_req && !gnt0;
    c1_stall = c1_req && !gnt1;

    // A reset arriving while a response is in flight drops it.
    c0_rvalid = !rst && rsp_q.valid && (rsp_q.core_id == CORE0);
    c1_rvalid = !rst && rsp_q.valid && (rsp_q.core_id == CORE1);

    c0_rdata   = c0_rvalid ? mem_rdata : c0_rdata_q;
    c1_rdata   = c1_rvalid ? mem_rdata : c1_rdata_q;
    c0_rdata_d = c0_rdata;
    c1_rdata_d = c1_rdata;

    c0_cnt_d = c0_cnt_q;
    c1_cnt_d = c1_cnt_q;
    if (c0_stall && !(&c0_cnt_q)) c0_cnt_d = c0_cnt_q + CNT_W'(1);
    if (c1_stall && !(&c1_cnt_q)) c1_cnt_d = c1_cnt_q + CNT_W'(1);
  end

  assign c0_stall_cnt = c0_cnt_q;
  assign c1_stall_cnt = c1_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold_q <= '0;
      rsp_q       <= '0;
      c0_rdata_q  <= '0;
      c1_rdata_q  <= '0;
      c0_cnt_q    <= '0;
      c1_cnt_q    <= '0;
    end else begin
      addr_hold_q <= addr_hold_d;
      rsp_q       <= rsp_d;
      c0_rdata_q  <= c0_rdata_d;
      c1_rdata_q  <= c1_rdata_d;
      c0_cnt_q    <= c0_cnt_d;
      c1_cnt_q    <= c1_cnt_d;
    end
  end

endmodule

// File: tb/tb_dualcore_mem_arbiter.sv
module tb_dualcore_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_req, c1_req, c0_wen, c1_wen;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_stall, c1_stall, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [CW-1:0] c0_stall_cnt, c1_stall_cnt;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dualcore_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_wen(c0_wen), .c0_wdata(c0_wdata),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_wen(c1_wen), .c1_wdata(c1_wdata),
    .c0_stall(c0_stall), .c1_stall(c1_stall),
    .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .c0_stall_cnt(c0_stall_cnt), .c1_stall_cnt(c1_stall_cnt),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Power-on RAM contents: a fixed pattern, with 0xABCD at 0x010.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 12'h010) return 16'hABCD;
    return (16'(a) * 16'h03B1) ^ 16'h5A5A;
  endfunction

  // Write-first synchronous RAM.
  logic [DW-1:0] ram [0:4095];
  bit            ram_wr [0:4095];
  always @(posedge clk) begin
    if (mem_wen) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
      mem_rdata        <= mem_wdata;
    end else begin
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [int];
  int            prio_m;
  int            cnt_m [2];
  logic [AW-1:0] hold_m;
  logic [DW-1:0] rd_m [2];

  typedef struct {
    int            due;
    int            core;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  int cyc;
  int errors;
  int checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  // One bus cycle: drive, predict, compare combinational outputs, advance model.
  task automatic step(input logic r,
                      input logic q0, input logic [AW-1:0] a0, input logic w0, input logic [DW-1:0] d0,
                      input logic q1, input logic [AW-1:0] a1, input logic w1, input logic [DW-1:0] d1);
    int            win;
    logic          upd;
    logic          wwen;
    logic [AW-1:0] waddr, exp_addr;
    logic          st0, st1;
    @(posedge clk);
    #2;
    cyc++;
    rst = r;
    c0_req = q0; c0_addr = a0; c0_wen = w0; c0_wdata = d0;
    c1_req = q1; c1_addr = a1; c1_wen = w1; c1_wdata = d1;
    if (r) while (sbq.size() > 0 && sbq[0].due == cyc) void'(sbq.pop_front());

    win = -1;
    upd = 1'b1;
    if (!r) begin
      if (q0 && q1) begin
        win = prio_m;
`ifdef ARB_STORE_PRIORITY_EN
        if (w0 != w1) begin
          win = w0 ? 0 : 1;
          upd = 1'b0;
        end
`endif
        if (upd) prio_m = 1 - win;
      end else if (q0) win = 0;
      else if (q1) win = 1;
    end
    wwen     = (win == 1) ? w1 : w0;
    waddr    = (win == 1) ? a1 : a0;
    exp_addr = (win >= 0) ? waddr : hold_m;
    st0      = q0 && (win != 0);
    st1      = q1 && (win != 1);

    #1;
    chk("c0_stall", 32'(c0_stall), 32'(st0));
    chk("c1_stall", 32'(c1_stall), 32'(st1));
    chk("mem_wen", 32'(mem_wen), 32'((win >= 0) && wwen));
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (win >= 0 && wwen)
      chk("mem_wdata", 32'(mem_wdata), 32'((win == 1) ? d1 : d0));
    chk("c0_stall_cnt", 32'(c0_stall_cnt), 32'(cnt_m[0]));
    chk("c1_stall_cnt", 32'(c1_stall_cnt), 32'(cnt_m[1]));

    if (r) begin
      prio_m   = 0;
      hold_m   = '0;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
    end else begin
      hold_m = exp_addr;
      if (st0 && cnt_m[0] < 255) cnt_m[0]++;
      if (st1 && cnt_m[1] < 255) cnt_m[1]++;
      if (win >= 0) begin
        if (wwen) ref_mem[int'(waddr)] = (win == 1) ? d1 : d0;
        else begin
          exp_t e;
          e.due  = cyc + 1;
          e.core = win;
          e.data = ref_read(waddr);
          sbq.push_back(e);
        end
      end
    end
  endtask

  // Response monitor: compares read responses against the scoreboard.
  always @(negedge clk) begin
    logic e0, e1;
    e0 = 1'b0;
    e1 = 1'b0;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      void'(sbq.pop_front());
      chk("sb_stale", 32'(1), 32'(0));
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.core == 0) e0 = 1'b1; else e1 = 1'b1;
      rd_m[e.core] = e.data;
    end
    chk("c0_rvalid", 32'(c0_rvalid), 32'(e0));
    chk("c1_rvalid", 32'(c1_rvalid), 32'(e1));
    chk("c0_rdata", 32'(c0_rdata), 32'(rd_m[0]));
    chk("c1_rdata", 32'(c1_rdata), 32'(rd_m[1]));
    if (rst) begin
      rd_m[0] = '0;
      rd_m[1] = '0;
    end
  end

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    step(1'b0, 1'b1, a0, 1'b0, '0, 1'b1, a1, 1'b0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int p;
    p = $urandom_range(0, 8);
    return (p == 8) ? 12'h7F4 : AW'(p);
  endfunction

  initial begin
    rst = 1'b1;
    c0_req = 1'b0; c0_addr = '0; c0_wen = 1'b0; c0_wdata = '0;
    c1_req = 1'b0; c1_addr = '0; c1_wen = 1'b0; c1_wdata = '0;
    prio_m = 0; cnt_m[0] = 0; cnt_m[1] = 0; hold_m = '0;
    rd_m[0] = '0; rd_m[1] = '0;
    cyc = 0; errors = 0; checks = 0;

    // Reset: requests only stall, stores never reach the RAM.
    step(1'b1, 1'b1, 12'h100, 1'b1, 16'hDEAD, 1'b1, 12'h101, 1'b1, 16'hBEEF);
    step(1'b1, 1'b0, 12'h000, 1'b0, '0,       1'b1, 12'h102, 1'b0, '0);

    // Single requester read of 0x010.
    step(1'b0, 1'b1, 12'h010, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    idle();

    // Full contention, both reads: alternate grants.
    repeat (4) rd2(12'h001, 12'h002);
    idle();

    // Store then read back the same word.
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 12'h7F4, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 12'h7F4, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    idle();

    // Reset right after a read grant drops the response.
    step(1'b0, 1'b1, 12'h005, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 12'h006, 1'b1, 16'h7777, 1'b0, '0, 1'b0, '0);
    idle();

    // Read/store collision with prio = 0.
    step(1'b0, 1'b1, 12'h003, 1'b0, '0, 1'b1, 12'h006, 1'b1, 16'h00AA);
    step(1'b0, 1'b1, 12'h006, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    idle();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           logic'($urandom_range(0, 3) != 0), rand_addr(), logic'($urandom_range(0, 2) == 0), 16'($urandom),
           logic'($urandom_range(0, 3) != 0), rand_addr(), logic'($urandom_range(0, 2) == 0), 16'($urandom));
    end

    // Saturation: long contention from a clean reset.
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 530; i++) rd2(AW'(i), AW'(i + 1));
    idle();
    chk("c1_stall_cnt_sat", 32'(c1_stall_cnt), 32'h0000_00FF);
    chk("c0_stall_cnt_sat", 32'(c0_stall_cnt), 32'h0000_00FF);

    idle();
    idle();
    chk("sb_empty", 32'(sbq.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
